spi_master: RTL and testbench

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/spi_pkg.sv | 14 +
 rtl/spi_master_if.sv | 25 ++
 rtl/spi_clk_gen.sv | 42 ++++
 rtl/spi_master.sv | 105 ++++++++++
 tb/tb_spi_master.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and constants for the SPI byte master
package spi_pkg;

    localparam int SPI_DATA_W    = 8;
    localparam int SPI_BIT_CNT_W = $clog2(SPI_DATA_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEAD  = 2'd1,
        SHIFT = 2'd2,
        TRAIL = 2'd3
    } spi_state_t;

endpackage

// File: rtl/spi_master_if.sv
// rtl/spi_master_if.sv - host handshake plus serial pins of one SPI master
interface spi_master_if;
    import spi_pkg::*;

    logic                  start;
    logic [SPI_DATA_W-1:0] tx_data;
    logic [SPI_DATA_W-1:0] rx_data;
    logic                  busy;
    logic                  done;
    logic                  ss;
    logic                  sclk;
    logic                  mosi;
    logic                  miso;

    modport master (
        input  start, tx_data, miso,
        output rx_data, busy, done, ss, sclk, mosi
    );

    modport slave (
        output start, tx_data, miso,
        input  rx_data, busy, done, ss, sclk, mosi
    );

endinterface

// File: rtl/spi_clk_gen.sv
// rtl/spi_clk_gen.sv - half-period tick and sclk level generator
module spi_clk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic toggle_en,
    output logic tick,
    output logic sclk
);
    localparam int               CNT_W    = $clog2(CLK_DIV + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             sclk_q;

    // tick marks the last clk cycle of each half-period while running
    assign tick = en && (cnt_q == CNT_LAST);
    assign sclk = sclk_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (!en || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_q <= 1'b0;
        end else if (!en) begin
            sclk_q <= 1'b0;
        end else if (tick && toggle_en) begin
            sclk_q <= ~sclk_q;
        end
    end

endmodule

// File: rtl/spi_master.sv
// rtl/spi_master.sv - SPI mode-0 byte master; SPI_MASTER_LOOPBACK_EN feeds mosi back into the receiver
module spi_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input logic          clk,
    input logic          rst_n,
    spi_master_if.master bus
);
    localparam logic [SPI_BIT_CNT_W-1:0] LAST_BIT = SPI_BIT_CNT_W'(SPI_DATA_W - 1);

    spi_state_t               state_q;
    spi_state_t               state_d;
    logic [SPI_DATA_W-1:0]    tx_shift_q;
    logic [SPI_DATA_W-1:0]    rx_shift_q;
    logic [SPI_DATA_W-1:0]    rx_data_q;
    logic [SPI_BIT_CNT_W-1:0] bit_cnt_q;
    logic                     done_q;
    logic                     tick;
    logic                     sclk;
    logic                     accept;
    logic                     fall;
    logic                     last_fall;
    logic                     rx_bit;
    logic                     gen_en;
    logic                     gen_toggle;

    // The done cycle is already IDLE, so it is excluded explicitly to keep ss low a cycle
    assign accept     = bus.start && (state_q == IDLE) && !done_q;
    assign gen_en     = (state_q != IDLE);
    assign gen_toggle = (state_q == LEAD) || (state_q == SHIFT);
    assign fall       = tick && (state_q == SHIFT) && sclk;
    assign last_fall  = fall && (bit_cnt_q == LAST_BIT);

`ifdef SPI_MASTER_LOOPBACK_EN
    assign rx_bit = tx_shift_q[SPI_DATA_W-1];
`else
    assign rx_bit = bus.miso;
`endif

    spi_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (gen_en),
        .toggle_en (gen_toggle),
        .tick      (tick),
        .sclk      (sclk)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)    state_d = LEAD;
            LEAD:    if (tick)      state_d = SHIFT;
            SHIFT:   if (last_fall) state_d = TRAIL;
            TRAIL:   if (tick)      state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Both shifters move on the sclk fall; the tx shifter drains to zero so mosi idles low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            bit_cnt_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                tx_shift_q <= bus.tx_data;
                rx_shift_q <= '0;
                bit_cnt_q  <= '0;
            end else if (fall) begin
                tx_shift_q <= {tx_shift_q[SPI_DATA_W-2:0], 1'b0};
                rx_shift_q <= {rx_shift_q[SPI_DATA_W-2:0], rx_bit};
                bit_cnt_q  <= bit_cnt_q + 1'b1;
            end
            if ((state_q == TRAIL) && tick) begin
                done_q    <= 1'b1;
                rx_data_q <= rx_shift_q;
            end
        end
    end

    assign bus.ss      = (state_q != IDLE);
    assign bus.busy    = (state_q != IDLE);
    assign bus.done    = done_q;
    assign bus.sclk    = sclk;
    assign bus.mosi    = tx_shift_q[SPI_DATA_W-1];
    assign bus.rx_data = rx_data_q;

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - directed vector bench for spi_master at CLK_DIV 2, 1, 3 and 8
module tb_spi_master;

    localparam int NDUT = 4;
    localparam int DIVS [NDUT] = '{2, 1, 3, 8};
`ifdef SPI_MASTER_LOOPBACK_EN
    localparam bit LOOPBACK = 1'b1;
`else
    localparam bit LOOPBACK = 1'b0;
`endif

    typedef struct {
        int         idx;
        logic [7:0] tx;
        logic [7:0] sb;
        int         exp_done;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_a [NDUT];
    logic [7:0] tx_a    [NDUT];
    logic [7:0] sbyte_a [NDUT];
    logic       ss_a    [NDUT];
    logic       sclk_a  [NDUT];
    logic       mosi_a  [NDUT];
    logic       busy_a  [NDUT];
    logic       done_a  [NDUT];
    logic [7:0] rx_a    [NDUT];
    int         n_cmp = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        spi_master_if bus ();
        logic miso_q;
        int   sidx;

        assign bus.start   = start_a[g];
        assign bus.tx_data = tx_a[g];
        assign bus.miso    = miso_q;
        assign ss_a[g]     = bus.ss;
        assign sclk_a[g]   = bus.sclk;
        assign mosi_a[g]   = bus.mosi;
        assign busy_a[g]   = bus.busy;
        assign done_a[g]   = bus.done;
        assign rx_a[g]     = bus.rx_data;

        spi_master #(
            .CLK_DIV (DIVS[g])
        ) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );

        // slave model: presents the next bit MSB-first on every sclk rise
        always @(posedge bus.sclk or negedge bus.ss) begin
            if (!bus.ss) begin
                sidx = 0;
            end else begin
                if (sidx < 8) miso_q = sbyte_a[g][3'(7 - sidx)];
                sidx = sidx + 1;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
        $fatal(1, "timeout");
    end

    function automatic logic [7:0] expect_rx(input logic [7:0] tx, input logic [7:0] sb);
        return LOOPBACK ? tx : sb;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic run_xfer(input int i, input logic [7:0] tx, input logic [7:0] sb,
                            output int done_cyc, output logic [7:0] bits, output int rises,
                            output logic [7:0] rx, output int viol, output int first_ok);
        logic prev;
        @(negedge clk);
        tx_a[i] = tx; sbyte_a[i] = sb; start_a[i] = 1'b1;
        done_cyc = -1; bits = '0; rises = 0; rx = '0; viol = 0; first_ok = 0; prev = 1'b0;
        for (int c = 1; c < 400; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start_a[i] = 1'b0;
                tx_a[i]    = ~tx;
                first_ok   = int'(ss_a[i] && busy_a[i] && (mosi_a[i] == tx[7]));
            end
            if (!ss_a[i] && sclk_a[i]) viol++;
            if (sclk_a[i] && !prev) begin
                if (!ss_a[i]) viol++;
                rises++;
                bits = {bits[6:0], mosi_a[i]};
            end
            prev = sclk_a[i];
            if (done_a[i]) begin
                done_cyc = c;
                rx = rx_a[i];
                if (ss_a[i] || busy_a[i]) viol++;
                break;
            end
        end
    endtask

    initial begin
        vec_t       vecs [9];
        int         dcyc, rises, viol, first_ok, ndone;
        logic [7:0] bits, rx;
        logic       prev;

        vecs[0] = '{0, 8'hA5, 8'h3C, 35};
        vecs[1] = '{0, 8'hFF, 8'h00, 35};
        vecs[2] = '{0, 8'h00, 8'hFF, 35};
        vecs[3] = '{0, 8'h81, 8'h7E, 35};
        vecs[4] = '{0, 8'h5A, 8'hFF, 35};
        vecs[5] = '{1, 8'hC3, 8'h5A, 18};
        vecs[6] = '{2, 8'h1E, 8'hE1, 52};
        vecs[7] = '{3, 8'h69, 8'h96, 137};
        vecs[8] = '{1, 8'h01, 8'h80, 18};

        for (int i = 0; i < NDUT; i++) begin
            start_a[i] = 1'b0; tx_a[i] = 8'h00; sbyte_a[i] = 8'h00;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ss",   int'(ss_a[0]),   0);
        check("reset_sclk", int'(sclk_a[0]), 0);
        check("reset_mosi", int'(mosi_a[0]), 0);
        check("reset_busy", int'(busy_a[0]), 0);
        check("reset_done", int'(done_a[0]), 0);
        check("reset_rx",   int'(rx_a[3]),   0);
        rst_n = 1'b1;

        for (int v = 0; v < 9; v++) begin
            run_xfer(vecs[v].idx, vecs[v].tx, vecs[v].sb, dcyc, bits, rises, rx, viol, first_ok);
            check($sformatf("v%0d cycle1_ss_busy_msb", v), first_ok, 1);
            check($sformatf("v%0d done_cycle", v), dcyc, vecs[v].exp_done);
            check($sformatf("v%0d mosi_bits", v), int'(bits), int'(vecs[v].tx));
            check($sformatf("v%0d sclk_rises", v), rises, 8);
            check($sformatf("v%0d sclk_ss_violations", v), viol, 0);
            check($sformatf("v%0d rx_data", v), int'(rx), int'(expect_rx(vecs[v].tx, vecs[v].sb)));
        end

        // CLK_DIV=1, start held: accepts at cycles 0 and 19, ss low in the done cycle 18
        @(negedge clk);
        tx_a[1] = 8'h96; sbyte_a[1] = 8'h69; start_a[1] = 1'b1;
        ndone = 0;
        for (int c = 1; c <= 38; c++) begin
            @(negedge clk);
            if (done_a[1]) ndone++;
            if (c == 17) check("b2b_ss_c17", int'(ss_a[1]), 1);
            if (c == 18) check("b2b_ss_c18", int'(ss_a[1]), 0);
            if (c == 18) check("b2b_done_c18", int'(done_a[1]), 1);
            if (c == 19) check("b2b_ss_c19", int'(ss_a[1]), 0);
            if (c == 20) check("b2b_ss_c20", int'(ss_a[1]), 1);
            if (c == 37) check("b2b_done_c37", int'(done_a[1]), 1);
            if (c == 37) check("b2b_rx", int'(rx_a[1]), int'(expect_rx(8'h96, 8'h69)));
        end
        start_a[1] = 1'b0;
        check("b2b_done_count", ndone, 2);
        @(negedge clk);
        check("b2b_ss_after", int'(ss_a[1]), 0);

        // starts during busy and in the done cycle are dropped; tx_data change has no effect
        @(negedge clk);
        tx_a[0] = 8'hC6; sbyte_a[0] = 8'h1B; start_a[0] = 1'b1;
        ndone = 0; bits = '0; prev = 1'b0; dcyc = -1; rx = '0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            start_a[0] = (c == 5) || (c == 20) || (c == 35);
            if (c == 1) tx_a[0] = 8'h3F;
            if (sclk_a[0] && !prev) bits = {bits[6:0], mosi_a[0]};
            prev = sclk_a[0];
            if (done_a[0]) begin
                ndone++; dcyc = c; rx = rx_a[0];
            end
            if (c == 36) check("ign_ss_after_done", int'(ss_a[0]), 0);
        end
        start_a[0] = 1'b0;
        check("ign_done_count", ndone, 1);
        check("ign_done_cycle", dcyc, 35);
        check("ign_mosi_bits", int'(bits), 32'hC6);
        check("ign_rx", int'(rx), int'(expect_rx(8'hC6, 8'h1B)));

        // reset in cycle 10 of a transfer aborts everything at once
        @(negedge clk);
        tx_a[0] = 8'hFF; sbyte_a[0] = 8'h00; start_a[0] = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) start_a[0] = 1'b0;
        end
        check("abort_pre_ss", int'(ss_a[0]), 1);
        check("abort_pre_mosi", int'(mosi_a[0]), 1);
        rst_n = 1'b0;
        #1;
        check("abort_ss",   int'(ss_a[0]),   0);
        check("abort_sclk", int'(sclk_a[0]), 0);
        check("abort_mosi", int'(mosi_a[0]), 0);
        check("abort_busy", int'(busy_a[0]), 0);
        check("abort_rx",   int'(rx_a[0]),   0);
        ndone = 0;
        repeat (3) begin
            @(negedge clk);
            if (done_a[0]) ndone++;
        end
        rst_n = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (done_a[0]) ndone++;
        end
        check("abort_no_done", ndone, 0);
        check("abort_idle_ss", int'(ss_a[0]), 0);

        // start presented with reset release is taken on the very first edge
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; tx_a[0] = 8'h42; sbyte_a[0] = 8'h24; start_a[0] = 1'b1;
        @(negedge clk);
        start_a[0] = 1'b0;
        check("first_start_ss", int'(ss_a[0]), 1);
        dcyc = -1;
        for (int c = 2; c < 100; c++) begin
            @(negedge clk);
            if (done_a[0]) begin
                dcyc = c;
                break;
            end
        end
        check("first_start_done_cycle", dcyc, 35);
        check("first_start_rx", int'(rx_a[0]), int'(expect_rx(8'h42, 8'h24)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
